// File: rtl/bp_gshare.sv
// Gshare branch predictor: PC tag XOR speculative global history indexes a
// table of saturating counters; ROB commit trains the table and repairs history.
module bp_gshare #(
  parameter int IDX_W  = 8,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 8,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_fetcher_valid,
  input  logic [IDX_W-1:0]  in_fetcher_tag,
  output logic              out_fetcher_jump_res,
  output logic [HIST_W-1:0] out_fetcher_hist,
  input  logic              in_rob_bp_res,
  input  logic [IDX_W-1:0]  in_rob_tag,
  input  logic [HIST_W-1:0] in_rob_hist,
  input  logic              in_rob_jump_res,
  input  logic              in_rob_mispredict,
  output logic [STAT_W-1:0] out_branch_cnt,
  output logic [STAT_W-1:0] out_mispredict_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  table_reg [DEPTH];
  logic [HIST_W-1:0] ghr_reg, ghr_next;
  logic [STAT_W-1:0] branch_cnt_reg, branch_cnt_next;
  logic [STAT_W-1:0] mispredict_cnt_reg, mispredict_cnt_next;

  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  train_idx;
  logic [CNT_W-1:0]  train_cnt;
  logic [CNT_W-1:0]  train_cnt_next;
  logic              train_en;
  logic              recover_en;
  logic [HIST_W-1:0] ghr_spec;
  logic [HIST_W-1:0] ghr_recover;

  assign pred_idx  = in_fetcher_tag ^ IDX_W'(ghr_reg);
  assign train_idx = in_rob_tag ^ IDX_W'(in_rob_hist);

  // Combinational read: the fetcher needs the prediction in the same cycle.
  assign out_fetcher_jump_res = table_reg[pred_idx][CNT_W-1];
  assign out_fetcher_hist     = ghr_reg;

  assign train_en   = in_rob_bp_res;
  assign recover_en = in_rob_bp_res && in_rob_mispredict;

  // Shifted history values; a 1-bit history simply holds the newest outcome.
  generate
    if (HIST_W == 1) begin : g_hist_one
      assign ghr_spec    = out_fetcher_jump_res;
      assign ghr_recover = in_rob_jump_res;
    end else begin : g_hist_shift
      assign ghr_spec    = {ghr_reg[HIST_W-2:0], out_fetcher_jump_res};
      assign ghr_recover = {in_rob_hist[HIST_W-2:0], in_rob_jump_res};
    end
  endgenerate

  always_comb begin
    train_cnt      = table_reg[train_idx];
    train_cnt_next = train_cnt;
    if (in_rob_jump_res) begin
      if (train_cnt != CNT_MAX) train_cnt_next = train_cnt + 1'b1;
    end else begin
      if (train_cnt != '0) train_cnt_next = train_cnt - 1'b1;
    end
  end

  // A mispredict flushes whatever was fetched alongside it, so recovery wins.
  always_comb begin
    ghr_next = ghr_reg;
    if (recover_en) begin
      ghr_next = ghr_recover;
    end else if (in_fetcher_valid) begin
      ghr_next = ghr_spec;
    end
  end

  always_comb begin
    branch_cnt_next     = branch_cnt_reg;
    mispredict_cnt_next = mispredict_cnt_reg;
    if (in_rob_bp_res) begin
      if (branch_cnt_reg != {STAT_W{1'b1}})
        branch_cnt_next = branch_cnt_reg + 1'b1;
      if (in_rob_mispredict && (mispredict_cnt_reg != {STAT_W{1'b1}}))
        mispredict_cnt_next = mispredict_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_reg[i] <= CNT_INIT;
    end else if (rdy && train_en) begin
      table_reg[train_idx] <= train_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_reg            <= '0;
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else if (rdy) begin
      ghr_reg            <= ghr_next;
      branch_cnt_reg     <= branch_cnt_next;
      mispredict_cnt_reg <= mispredict_cnt_next;
    end
  end

  assign out_branch_cnt     = branch_cnt_reg;
  assign out_mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_bp_gshare.sv
// Directed bench for bp_gshare (IDX_W=8, CNT_W=2, HIST_W=8, STAT_W=4).
module tb_bp_gshare;
  localparam int IDX_W  = 8;
  localparam int HIST_W = 8;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              in_fetcher_valid;
  logic [IDX_W-1:0]  in_fetcher_tag;
  logic              out_fetcher_jump_res;
  logic [HIST_W-1:0] out_fetcher_hist;
  logic              in_rob_bp_res;
  logic [IDX_W-1:0]  in_rob_tag;
  logic [HIST_W-1:0] in_rob_hist;
  logic              in_rob_jump_res;
  logic              in_rob_mispredict;
  logic [STAT_W-1:0] out_branch_cnt;
  logic [STAT_W-1:0] out_mispredict_cnt;

  int checks   = 0;
  int failures = 0;

  bp_gshare #(.IDX_W(IDX_W), .CNT_W(2), .HIST_W(HIST_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetcher_valid(in_fetcher_valid), .in_fetcher_tag(in_fetcher_tag),
    .out_fetcher_jump_res(out_fetcher_jump_res), .out_fetcher_hist(out_fetcher_hist),
    .in_rob_bp_res(in_rob_bp_res), .in_rob_tag(in_rob_tag), .in_rob_hist(in_rob_hist),
    .in_rob_jump_res(in_rob_jump_res), .in_rob_mispredict(in_rob_mispredict),
    .out_branch_cnt(out_branch_cnt), .out_mispredict_cnt(out_mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic commit(input logic [7:0] tag, input logic [7:0] hist,
                        input logic taken, input logic mis);
    in_rob_bp_res     = 1'b1;
    in_rob_tag        = tag;
    in_rob_hist       = hist;
    in_rob_jump_res   = taken;
    in_rob_mispredict = mis;
    tick();
    in_rob_bp_res     = 1'b0;
    in_rob_mispredict = 1'b0;
  endtask

  task automatic pred(input string tag, input logic [7:0] ftag, input logic exp);
    in_fetcher_tag = ftag;
    #1;
    check(tag, 32'(out_fetcher_jump_res), 32'(exp));
  endtask

  task automatic stats(input string tag, input int b, input int m);
    check({tag, "_branch"}, 32'(out_branch_cnt), 32'(b));
    check({tag, "_mis"}, 32'(out_mispredict_cnt), 32'(m));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    in_fetcher_valid = 1'b0; in_fetcher_tag = '0;
    in_rob_bp_res = 1'b0; in_rob_tag = '0; in_rob_hist = '0;
    in_rob_jump_res = 1'b0; in_rob_mispredict = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_hist", 32'(out_fetcher_hist), 32'h00);
    stats("reset", 0, 0);

    // First fetch: weakly-taken table, history shifts in a 1
    in_fetcher_valid = 1'b1;
    pred("fetch0_pred", 8'h00, 1'b1);
    check("fetch0_hist", 32'(out_fetcher_hist), 32'h00);
    tick();
    in_fetcher_valid = 1'b0;
    check("fetch0_hist_next", 32'(out_fetcher_hist), 32'h01);

    // Mispredict not-taken on 0x05 restores GHR to 0 and trains 2->1
    commit(8'h05, 8'h00, 1'b0, 1'b1);
    check("recover_hist0", 32'(out_fetcher_hist), 32'h00);
    pred("t05_after1", 8'h05, 1'b0);
    commit(8'h05, 8'h00, 1'b0, 1'b0);
    commit(8'h05, 8'h00, 1'b0, 1'b0);
    pred("t05_sat0", 8'h05, 1'b0);
    commit(8'h05, 8'h00, 1'b1, 1'b0);
    pred("t05_up1", 8'h05, 1'b0);
    commit(8'h05, 8'h00, 1'b1, 1'b0);
    pred("t05_up2", 8'h05, 1'b1);
    stats("after_t05", 5, 1);

    // Tag 0x10 with hist 0x03 trains entry 0x13 to saturation
    for (int i = 0; i < 4; i++) commit(8'h10, 8'h03, 1'b1, 1'b0);
    pred("t13_sat3", 8'h13, 1'b1);
    commit(8'h10, 8'h03, 1'b0, 1'b0);
    pred("t13_dec2", 8'h13, 1'b1);
    in_fetcher_valid = 1'b1;
    in_fetcher_tag = 8'h00;
    tick();
    tick();
    in_fetcher_valid = 1'b0;
    check("ghr_03", 32'(out_fetcher_hist), 32'h03);
    pred("t10_alias13", 8'h10, 1'b1);

    // Recovery to 0xAA, then recovery vs. same-cycle fetch shift
    commit(8'h00, 8'h55, 1'b0, 1'b1);
    check("ghr_AA", 32'(out_fetcher_hist), 32'hAA);
    in_fetcher_valid = 1'b1;
    in_fetcher_tag = 8'h00;
    commit(8'h00, 8'h3C, 1'b1, 1'b1);
    check("recover_wins", 32'(out_fetcher_hist), 32'h79);
    stats("after_recover", 12, 3);

    // rdy low: fetch and mispredict commit must not change anything
    rdy = 1'b0;
    in_fetcher_tag = 8'h6A;
    in_rob_bp_res = 1'b1; in_rob_tag = 8'h13; in_rob_hist = 8'h00;
    in_rob_jump_res = 1'b0; in_rob_mispredict = 1'b1;
    tick(); tick(); tick();
    check("hold_hist", 32'(out_fetcher_hist), 32'h79);
    stats("hold", 12, 3);
    pred("hold_t13", 8'h6A, 1'b1);
    rdy = 1'b1;
    tick();
    in_fetcher_valid = 1'b0; in_rob_bp_res = 1'b0; in_rob_mispredict = 1'b0;
    check("resume_hist", 32'(out_fetcher_hist), 32'h00);
    stats("resume", 13, 4);
    pred("resume_t13", 8'h13, 1'b0);

    // Mispredict flag without a commit is ignored
    in_rob_mispredict = 1'b1; in_rob_hist = 8'hFF; in_rob_jump_res = 1'b1;
    tick();
    in_rob_mispredict = 1'b0;
    check("lone_mis_hist", 32'(out_fetcher_hist), 32'h00);
    stats("lone_mis", 13, 4);

    // Reset restores table, then stats saturate at 4 bits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stats("rst2", 0, 0);
    pred("rst2_t13", 8'h13, 1'b1);
    for (int i = 0; i < 17; i++) commit(8'h20, 8'h00, 1'b1, (i >= 12) ? 1'b1 : 1'b0);
    stats("sat", 15, 5);
    check("sat_hist", 32'(out_fetcher_hist), 32'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stats("rst3", 0, 0);
    check("rst3_hist", 32'(out_fetcher_hist), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bp_gshare.md
Name: bp_gshare

Overview:
Parametrised gshare branch predictor, successor to the 256-entry bimodal predictor. Fetcher gets a taken/not-taken prediction indexed by PC tag XOR a speculative global history register (GHR). ROB commit trains saturating counters, and on a mispredict restores the GHR. Also keeps branch/mispredict statistics counters for performance debug.

Parameters:
IDX_W, 8, table index width; table holds 2^IDX_W counters
CNT_W, 2, saturating counter width (>=2)
HIST_W, 8, GHR length in bits (1..IDX_W)
STAT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; all state frozen when low
in_fetcher_valid  in  1  fetcher consumes a prediction for a branch this cycle
in_fetcher_tag  in  IDX_W  PC-derived tag of the branch being fetched
out_fetcher_jump_res  out  1  predicted taken (combinational)
out_fetcher_hist  out  HIST_W  current GHR value, carried with the instruction to the ROB
in_rob_bp_res  in  1  a conditional branch commits this cycle
in_rob_tag  in  IDX_W  tag of the committing branch
in_rob_hist  in  HIST_W  GHR snapshot taken when that branch was predicted
in_rob_jump_res  in  1  actual outcome, 1 = taken
in_rob_mispredict  in  1  prediction was wrong; valid only with in_rob_bp_res
out_branch_cnt  out  STAT_W  committed conditional branches
out_mispredict_cnt  out  STAT_W  committed mispredicts

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: every counter = 2^(CNT_W-1) (weakly taken); GHR = 0; both stat counters = 0. Reset has priority over rdy.
- rdy low and no reset: no table, GHR or stat change. Outputs still reflect current state.
- Predict index: pi = in_fetcher_tag XOR zero-extended GHR (HIST_W LSBs aligned to bit 0).
- out_fetcher_jump_res = MSB of table[pi].
- Prediction is combinational, zero latency. out_fetcher_hist = GHR.
- Speculative GHR update: on rdy and in_fetcher_valid, GHR <= {GHR[HIST_W-2:0], out_fetcher_jump_res}. For HIST_W=1, GHR <= prediction.
- Recovery: on rdy, in_rob_bp_res and in_rob_mispredict, GHR <= {in_rob_hist[HIST_W-2:0], in_rob_jump_res}.
  - Recovery overrides a same-cycle fetch shift; the fetched prediction is considered flushed.
- Train index: ti = in_rob_tag XOR zero-extended in_rob_hist.
- Training: on rdy and in_rob_bp_res:
  - taken: table[ti] increments, saturating at 2^CNT_W-1.
  - not taken: table[ti] decrements, saturating at 0.
  - Update is visible the next cycle.
- Same-cycle read/write of the same entry: prediction uses the pre-update value; no bypass.
- in_rob_mispredict without in_rob_bp_res is ignored.
- Stats, on rdy and in_rob_bp_res:
  - out_branch_cnt += 1.
  - out_mispredict_cnt += 1 if in_rob_mispredict.
  - Both saturate at all-ones; they do not wrap.
- Reset mid-stream: all speculative history is lost. In-flight ROB hist snapshots remain legal inputs and need no special handling.
- Single commit port and single predict port per cycle.

Test Plan:
- Reset with defaults, then fetch tag 0x00 with valid -> jump_res=1, hist=0x00. Next cycle hist=0x01.
- Commit tag 0x05, hist 0x00, not taken, twice -> table[0x05] goes 2->1->0. With GHR=0, fetch tag 0x05 -> jump_res=0. A third not-taken commit keeps it at 0 (saturation).
- Four taken commits to tag 0x10, hist 0x03 -> entry 0x13 saturates at 3. Fetch tag 0x10 while GHR=0x03 -> 1. Fetch tag 0x13 while GHR=0x00 -> 1 (same entry).
- Same cycle: fetch valid with GHR=0xAA, plus commit mispredict with rob_hist=0x3C, taken -> next GHR=0x79, not 0x55/0x54.
- Hold rdy=0 for 3 cycles while driving fetch valid and commits -> GHR, table and stats are unchanged. Raise rdy -> normal operation resumes.
- STAT_W=4: 17 commits, 5 of them mispredicts -> branch_cnt=15 (saturated), mispredict_cnt=5. Assert rst -> both 0 and GHR 0 next cycle.
